// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder, one GROUP-bit lookahead group per stage; define CLA_OVERFLOW_EN to add the overflow output
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             C0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef CLA_OVERFLOW_EN
    output logic             carry_out,
    output logic             overflow
`else
    output logic             carry_out
`endif
);
    localparam int G      = (GROUP < 1) ? 1 : GROUP;
    localparam int STAGES = WIDTH / G;

    if (GROUP < 1) begin : g_bad_group
        $error("pipelined_cla_adder: GROUP must be at least 1");
    end else if (WIDTH % GROUP != 0) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
    end

    // every carry is a flat sum of products over g/p/ci, so no carry waits on another
    function automatic logic [G:0] lookahead(input logic [G-1:0] g, input logic [G-1:0] p, input logic ci);
        logic [G:0] c;
        logic       t;
        c = '0;
        for (int i = 0; i <= G; i++) begin
            t = ci;
            for (int j = 0; j < i; j++) t = t & p[j];
            c[i] = t;
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int m = j + 1; m < i; m++) t = t & p[m];
                c[i] = c[i] | t;
            end
        end
        return c;
    endfunction

    logic [STAGES-1:0] r_v, r_c, w_ld, w_vi, w_ci, w_cn;
    logic [WIDTH-1:0]  r_x [STAGES];
    logic [WIDTH-1:0]  r_y [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic [WIDTH-1:0]  w_xi [STAGES];
    logic [WIDTH-1:0]  w_yi [STAGES];
    logic [WIDTH-1:0]  w_si [STAGES];
    logic [WIDTH-1:0]  w_sn [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [G-1:0] w_g, w_p;
        logic [G:0]   w_c;
        if (k == 0) begin : g_first
            assign w_xi[k] = X;
            assign w_yi[k] = Y;
            assign w_si[k] = '0;
            assign w_ci[k] = C0;
            assign w_vi[k] = in_valid;
        end else begin : g_next
            assign w_xi[k] = r_x[k-1];
            assign w_yi[k] = r_y[k-1];
            assign w_si[k] = r_s[k-1];
            assign w_ci[k] = r_c[k-1];
            assign w_vi[k] = r_v[k-1];
        end
        assign w_g     = w_xi[k][k*G +: G] & w_yi[k][k*G +: G];
        assign w_p     = w_xi[k][k*G +: G] ^ w_yi[k][k*G +: G];
        assign w_c     = lookahead(w_g, w_p, w_ci[k]);
        assign w_sn[k] = w_si[k] | (WIDTH'(w_p ^ w_c[G-1:0]) << (k * G));
        assign w_cn[k] = w_c[G];
    end

    // a stage loads when empty or when its successor loads, so bubbles collapse
    always_comb begin
        w_ld = '0;
        w_ld[STAGES-1] = !r_v[STAGES-1] || out_ready;
        for (int i = STAGES - 2; i >= 0; i--) w_ld[i] = !r_v[i] || w_ld[i+1];
    end

`ifdef CLA_OVERFLOW_EN
    logic w_ov, r_ov;
    assign w_ov = (w_xi[STAGES-1][WIDTH-1] == w_yi[STAGES-1][WIDTH-1]) &&
                  (w_sn[STAGES-1][WIDTH-1] != w_xi[STAGES-1][WIDTH-1]);
    assign overflow = r_ov;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_ov <= 1'b0;
        else if (w_ld[STAGES-1] && w_vi[STAGES-1]) r_ov <= w_ov;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_v <= '0;
            r_c <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
                r_s[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++)
                if (w_ld[i]) begin
                    r_v[i] <= w_vi[i];
                    if (w_vi[i]) begin
                        r_x[i] <= w_xi[i];
                        r_y[i] <= w_yi[i];
                        r_s[i] <= w_sn[i];
                        r_c[i] <= w_cn[i];
                    end
                end
        end

    assign in_ready  = w_ld[0];
    assign out_valid = r_v[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign carry_out = r_c[STAGES-1];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: scoreboard bench for pipelined_cla_adder, overflow checked when CLA_OVERFLOW_EN is defined
module tb_pipelined_cla_adder;
    localparam int W  = 32;
    localparam int GR = 8;
    localparam int ST = W / GR;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, C0 = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, carry_out;
    logic [W-1:0] X = '0, Y = '0, sum;
`ifdef CLA_OVERFLOW_EN
    logic         overflow;
`endif

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(GR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .C0(C0), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum),
`ifdef CLA_OVERFLOW_EN
        .carry_out(carry_out), .overflow(overflow)
`else
        .carry_out(carry_out)
`endif
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t         q[$];
    int           checks = 0, errors = 0, n_out = 0, n_acc = 0;
    logic [W-1:0] last_sum = '0;
    logic         last_c = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // reference: plain integer arithmetic, signed range test for overflow
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t   e;
        longint u, s;
        u = longint'(a) + longint'(b) + longint'(c);
        s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        e.s = u[W-1:0];
        e.c = u[W];
        e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int t = 0;
        bit done = 0;
        X = a; Y = b; C0 = c; in_valid = 1'b1;
        while (!done && t < 200) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(model(a, b, c));
                n_acc++;
                done = 1;
            end
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        if (!done) chk("send_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain(input int lim);
        int t = 0;
        while (q.size() > 0 && t < lim) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_pending", 64'(q.size()), 64'd0);
    endtask

    // monitor: pop on every consumed output, check stability while stalled
    initial begin
        exp_t e, held;
        bit   held_v = 0;
        forever begin
            @(negedge clk);
            if (rst) held_v = 0;
            else if (out_valid) begin
                if (held_v) chk("stall_hold", 64'({carry_out, sum}), 64'({held.c, held.s}));
                if (out_ready) begin
                    held_v = 0;
                    if (q.size() == 0) chk("unexpected_output", 64'({carry_out, sum}), 64'hDEAD_0000_0000_0000);
                    else begin
                        e = q.pop_front();
                        chk("sum_carry", 64'({carry_out, sum}), 64'({e.c, e.s}));
`ifdef CLA_OVERFLOW_EN
                        chk("overflow", 64'(overflow), 64'(e.o));
`endif
                    end
                    n_out++;
                    last_sum = sum;
                    last_c   = carry_out;
                end else begin
                    held_v = 1;
                    held.s = sum;
                    held.c = carry_out;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, base, base_out;
        bit stop;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_carry", 64'(carry_out), 64'd0);
`ifdef CLA_OVERFLOW_EN
        chk("reset_overflow", 64'(overflow), 64'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        send(32'd1, 32'd2, 1'b0);
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", 64'(cnt), 64'(ST));
        wait_drain(20);
        chk("basic_sum", 64'({last_c, last_sum}), 64'd3);

        send(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_drain(20);
        chk("carry_chain", 64'({last_c, last_sum}), 64'h1_0000_0000);
        send(32'hFFFF_FFFF, 32'd0, 1'b1);
        wait_drain(20);
        chk("carry_in_chain", 64'({last_c, last_sum}), 64'h1_0000_0000);

        send(32'h7FFF_FFFF, 32'd1, 1'b0);
        wait_drain(20);
        chk("pos_overflow", 64'({last_c, last_sum}), 64'h0_8000_0000);
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_drain(20);
        chk("neg_overflow", 64'({last_c, last_sum}), 64'h1_0000_0000);

        out_ready = 1'b0;
        base = n_acc;
        fork
            for (int i = 1; i <= 8; i++) send(W'(i), W'(i), 1'b0);
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                chk("full_in_ready", 64'(in_ready), 64'd0);
                chk("full_accepts", 64'(n_acc - base), 64'd4);
                @(posedge clk); #1;
                out_ready = 1'b1;
                repeat (8) @(posedge clk);
                #1;
                chk("burst_throughput", 64'(q.size()), 64'd0);
            end
        join
        wait_drain(20);
        chk("burst_last", 64'(last_sum), 64'd16);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0);
        @(posedge clk); #1;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'd0);
        chk("async_reset_sum", 64'({carry_out, sum}), 64'd0);
        q.delete();
        base_out = n_out;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_output_after_reset", 64'(n_out - base_out), 64'd0);
        send(32'd5, 32'd6, 1'b0);
        wait_drain(20);
        chk("post_reset_add", 64'({last_c, last_sum}), 64'd11);

        send(32'd1, 32'd0, 1'b0);
        wait_drain(20);
        for (int i = 0; i < 200; i++) begin
            send(32'd1, last_sum, 1'b0);
            wait_drain(20);
        end
        chk("feedback_final", 64'({last_c, last_sum}), 64'd201);

        stop = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [W-1:0] a, b;
                    a = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                    b = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send(a, b, 1'($urandom_range(0, 1)));
                end
                stop = 1;
            end
            while (!stop) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 1'b1;
        wait_drain(100);
        chk("output_count", 64'(n_out), 64'(n_acc - 3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
